// File: rtl/seq_sum_product.sv
// Purpose: sequential sum/product stage: registered var1+var2 and a shift-add var1*var2.
// Latency: result valid exactly WIDTH edges after the accepting edge; issue interval is WIDTH+2.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready is seen.
module seq_sum_product #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     var1,
    input  logic [WIDTH-1:0]     var2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH:0]       sum,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;

    // Operands as accepted; kept intact so the sum uses the original values
    // while the multiplier copy is shifted away.
    logic [WIDTH-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]     opb_q, opb_d;

    // Multiplier bits still to be consumed, LSB first.
    logic [WIDTH-1:0]     mb_q, mb_d;

    // Running partial-product accumulator and iteration index.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    // Result registers presented on the output ports.
    logic [WIDTH:0]       sum_q, sum_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    // Datapath helpers for the current iteration.
    logic [2*WIDTH-1:0]   mcand_ext;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic                 last_iter;

    // Shift-add step: add the multiplicand shifted to the current bit position
    // when that multiplier bit is set.
    always_comb begin
        mcand_ext = {{WIDTH{1'b0}}, opa_q};
        addend    = '0;
        if (mb_q[0]) begin
            addend = mcand_ext << cnt_q;
        end
        acc_nxt   = acc_q + addend;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Next-state and datapath control; every register holds unless its state says otherwise.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        mb_d    = mb_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        prod_d  = prod_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opa_d   = var1;
                    opb_d   = var2;
                    mb_d    = var2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end

            CALC: begin
                // No early exit on a zero multiplier: latency is fixed.
                acc_d = acc_nxt;
                mb_d  = mb_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    prod_d  = acc_nxt;
                    sum_d   = {1'b0, opa_q} + {1'b0, opb_q};
                    state_d = DONE;
                end
            end

            DONE: begin
                // Results stay put until the consumer takes them; the return
                // to IDLE costs one cycle before the next operand is accepted.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            mb_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            mb_q    <= mb_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            prod_q  <= prod_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        product   = prod_q;
    end

    // A stalled result must not change underneath the consumer.
    a_hold_result: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> (out_valid && $stable(sum) && $stable(product)));

    // The iteration counter never runs past the last multiplier bit.
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        (state_q == CALC) |-> (cnt_q < CNT_W'(WIDTH)));

    // Never ready for input while a result is pending or being built.
    a_ready_excl: assert property (@(posedge clk) disable iff (rst)
        !(in_ready && busy));

endmodule

// File: tb/tb_seq_sum_product.sv
// Purpose: directed, self-checking bench for seq_sum_product with hand-computed results.
// Latency: checks the fixed 8-edge result latency and the 10-cycle issue interval.
// Backpressure: exercises out_ready stalls and in_valid held during CALC/DONE.
module tb_seq_sum_product;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  var1;
    logic [7:0]  var2;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  sum;
    logic [15:0] product;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    seq_sum_product #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .var1      (var1),
        .var2      (var2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Count edges until out_valid appears, bounded so the run always ends.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    // Present one pair for a single cycle; caller ensures the DUT is in IDLE.
    task automatic issue(input logic [7:0] a, input logic [7:0] b);
        var1     = a;
        var2     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Full transaction with out_ready already high.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [8:0] es, input logic [15:0] ep);
        int lat;
        issue(a, b);
        wait_done(lat);
        chk({tag, "_lat"}, lat, 8);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_prod"}, product, ep);
        tick();
        chk({tag, "_vld_drop"}, out_valid, 0);
        chk({tag, "_rdy_back"}, in_ready, 1);
    endtask

    initial begin
        int lat;
        int edges;
        int extra;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        var1      = '0;
        var2      = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_prod", product, 0);
        rst = 1'b0;
        tick();

        // 10 + 99, 10 * 99
        issue(8'd10, 8'd99);
        chk("t1_busy", busy, 1);
        chk("t1_in_ready_low", in_ready, 0);
        wait_done(lat);
        chk("t1_lat", lat, 8);
        chk("t1_sum", sum, 109);
        chk("t1_prod", product, 990);
        tick();
        chk("t1_vld_one_cycle", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);
        chk("t1_sum_kept", sum, 109);

        // Consumer stalls for 5 cycles; result must hold.
        out_ready = 1'b0;
        issue(8'd132, 8'd33);
        wait_done(lat);
        chk("t2_lat", lat, 8);
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_vld", out_valid, 1);
            chk("t2_hold_sum", sum, 165);
            chk("t2_hold_prod", product, 4356);
            if (i < 5) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("t2_xfer_done", out_valid, 0);
        tick();
        chk("t2_single_xfer", out_valid, 0);

        // Extremes
        run_op("t3_max", 8'd255, 8'd255, 9'd510, 16'd65025);
        run_op("t3_zero", 8'd0, 8'd200, 9'd200, 16'd0);

        // in_valid held high across two pairs
        var1     = 8'd4;
        var2     = 8'd4;
        in_valid = 1'b1;
        tick();
        var1 = 8'd33;
        var2 = 8'd5;
        wait_done(lat);
        edges = lat;
        chk("t4_first_lat", lat, 8);
        chk("t4_first_sum", sum, 8);
        chk("t4_first_prod", product, 16);
        tick();
        edges++;
        chk("t4_idle_ready", in_ready, 1);
        tick();
        edges++;
        in_valid = 1'b0;
        chk("t4_second_accept", busy, 1);
        chk("t4_interval", edges, 10);
        wait_done(lat);
        chk("t4_second_lat", lat, 8);
        chk("t4_second_sum", sum, 38);
        chk("t4_second_prod", product, 165);
        tick();
        chk("t4_second_drop", out_valid, 0);

        // Reset in the middle of CALC
        issue(8'd10, 8'd99);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_vld", out_valid, 0);
        chk("t5_rst_sum", sum, 0);
        chk("t5_rst_prod", product, 0);
        chk("t5_rst_ready", in_ready, 1);
        chk("t5_rst_busy", busy, 0);
        rst = 1'b0;
        tick();
        run_op("t5_after", 8'd5, 8'd6, 9'd11, 16'd30);

        // Stray in_valid pulse during CALC must not start a second operation
        issue(8'd7, 8'd3);
        tick();
        var1     = 8'd9;
        var2     = 8'd9;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        wait_done(lat);
        chk("t6_sum", sum, 10);
        chk("t6_prod", product, 21);
        tick();
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) extra++;
            tick();
        end
        chk("t6_no_second", extra, 0);
        chk("t6_idle", in_ready, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seq_sum_product.md
Name: seq_sum_product

Overview:
- Sequential arithmetic stage that accepts an 8-bit operand pair (var1, var2) over a valid/ready handshake.
- Returns their 9-bit sum and their 16-bit product.
- The product comes from an iterative shift-add multiplier, one bit per clock, instead of a combinational multiplier.
- Sits directly downstream of the operand-generating stimulus/procedure block and feeds the result monitor/consumer. Replaces the continuous-assign sum and the always-block product with a registered, handshaked equivalent.

Parameters:
- WIDTH, 8, operand width in bits. sum is WIDTH+1 bits; product is 2*WIDTH bits.
- CNT_W, 4, width of the iteration counter. Must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- var1  input  WIDTH  operand A (multiplicand).
- var2  input  WIDTH  operand B (multiplier).
- out_valid  output  1  sum/product valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH+1  var1+var2, registered.
- product  output  2*WIDTH  var1*var2, registered.
- busy  output  1  high in CALC or DONE.

Behaviour:
- All regs are updated only on the rising edge of clk. Reset is synchronous, active-high, and has priority over everything else.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, product=0. Internal acc, operand regs and counter are all 0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid && in_ready: latch a=var1 and b=var2; acc=0; cnt=0; go to CALC.
  - var1/var2 are ignored when in_valid=0.
- CALC:
  - in_ready=0.
  - Each edge: if b[0], acc = acc + (a zero-extended to 2*WIDTH, shifted left by cnt). Then b = b >> 1 and cnt = cnt + 1.
  - On the edge that completes iteration WIDTH (cnt==WIDTH-1): load product = final acc and sum = a+b_original (full WIDTH+1 bits, no truncation); out_valid=1; go to DONE.
  - The original operands are retained in a separate register for the sum.
  - Fixed latency: no early termination on b==0. out_valid rises exactly WIDTH edges after the accepting edge, i.e. 8 cycles at the default.
- DONE:
  - out_valid=1, in_ready=0. sum/product are held stable while out_valid && !out_ready.
  - On the edge where out_ready=1: out_valid=0 and go to IDLE. No new operand is accepted in that same cycle.
  - Minimum issue interval is WIDTH+2 cycles.
- After a handshake, sum/product keep their last values (out_valid=0) until the next DONE entry overwrites them.
- in_valid asserted during CALC/DONE is not consumed. The upstream holds it; it is accepted on the first IDLE cycle.
- out_ready asserted outside DONE has no effect.
- Reset asserted mid-CALC or mid-DONE: the operation is abandoned and all outputs return to reset values on that edge. No stale result is ever presented.
- Arithmetic is unsigned, with no overflow possible: max sum = 2*(2**WIDTH-1); max product = (2**WIDTH-1)**2.

Test Plan:
- Reset, then var1=10, var2=99, in_valid=1 for one cycle, out_ready=1 -> out_valid rises 8 cycles after acceptance with sum=109, product=990. out_valid is high for 1 cycle and in_ready returns the next cycle.
- var1=132, var2=33 with out_ready=0 for 5 cycles after out_valid, then 1 -> sum=165 and product=4356 held stable for all 6 cycles. A single transfer follows.
- var1=255, var2=255 -> sum=510, product=65025. Then var1=0, var2=200 -> sum=200, product=0, with the same fixed 8-cycle latency.
- in_valid held high continuously with pairs (4,4) then (33,5) -> first result 8/16. The second pair is accepted only after the DONE handshake and yields 38/165. Issue interval is 10 cycles.
- Reset asserted 3 cycles into CALC for (10,99) -> on that edge out_valid=0, sum=0, product=0, in_ready=1. A new pair (5,6) afterwards yields 11/30.
- in_valid pulse during CALC only, deasserted before IDLE -> no second result is produced, and out_valid fires exactly once.
